// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - Sequential load/store unit with sub-word read-modify-write; optional macro LSU_MISALIGN_TRAP_EN
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TYPE_W = 3,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [TYPE_W-1:0] req_type_i,
    input  logic [RD_W-1:0]   req_rd_i,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic [ADDR_W-3:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_wdata_o,
    input  logic [DATA_W-1:0] bram_rdata_i,
    output logic              wb_valid_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o
);
    localparam logic [TYPE_W-1:0] DT_BYTE  = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] DT_HALF  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] DT_WORD  = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] DT_UBYTE = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] DT_UHALF = TYPE_W'(5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_RD,
        S_LD_WAIT,
        S_RMW_RD,
        S_RMW_WAIT,
        S_WR,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [TYPE_W-1:0] type_q;
    logic [RD_W-1:0]   rd_q;
    logic [RD_W-1:0]   wb_rd_q;
    logic [DATA_W-1:0] bram_wdata_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_valid_q;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
    assign misalign_o = (state_q == S_ERR);
`else
    localparam bit TRAP_EN = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // Request decode: access size, misalignment, and aligned-down address
    logic              req_is_byte, req_is_half, req_is_word, req_misaligned;
    logic [ADDR_W-1:0] req_addr_al;
    always_comb begin
        req_is_byte    = (req_type_i == DT_BYTE) || (req_type_i == DT_UBYTE);
        req_is_half    = (req_type_i == DT_HALF) || (req_type_i == DT_UHALF);
        req_is_word    = (req_type_i == DT_WORD);
        req_misaligned = (req_is_half && req_addr_i[0]) ||
                         (req_is_word && (req_addr_i[1:0] != 2'b00));
        req_addr_al    = req_addr_i;
        if (req_is_half) req_addr_al[0] = 1'b0;
        if (req_is_word) req_addr_al[1:0] = 2'b00;
    end

    // Load lane extraction/extension and store lane merge against the read word
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;
    logic [DATA_W-1:0] st_merged;
    always_comb begin
        ld_byte = bram_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        ld_half = bram_rdata_i[{addr_q[1], 4'b0000} +: 16];
        ld_ext  = '0;
        case (type_q)
            DT_BYTE:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            DT_UBYTE: ld_ext = {24'h000000, ld_byte};
            DT_HALF:  ld_ext = {{16{ld_half[15]}}, ld_half};
            DT_UHALF: ld_ext = {16'h0000, ld_half};
            DT_WORD:  ld_ext = bram_rdata_i;
            default:  ld_ext = '0;
        endcase
        st_merged = bram_rdata_i;
        // Only byte or half stores reach the merge; the held store data is right-aligned
        if ((type_q == DT_BYTE) || (type_q == DT_UBYTE)) begin
            st_merged[{addr_q[1:0], 3'b000} +: 8] = bram_wdata_q[7:0];
        end else begin
            st_merged[{addr_q[1], 4'b0000} +: 16] = bram_wdata_q[15:0];
        end
    end

    // Next-state and BRAM/handshake controls
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (TRAP_EN && req_misaligned)          state_d = S_ERR;
                    else if (!req_we_i)                     state_d = S_LD_RD;
                    else if (req_is_word)                   state_d = S_WR;
                    else if (req_is_byte || req_is_half)    state_d = S_RMW_RD;
                    else                                    state_d = S_IDLE;
                end
            end
            S_LD_RD: begin
                bram_en_o = 1'b1;
                state_d   = S_LD_WAIT;
            end
            S_LD_WAIT:  state_d = S_IDLE;
            S_RMW_RD: begin
                bram_en_o = 1'b1;
                state_d   = S_RMW_WAIT;
            end
            S_RMW_WAIT: state_d = S_WR;
            S_WR: begin
                bram_en_o = 1'b1;
                bram_we_o = 1'b1;
                state_d   = S_IDLE;
            end
            S_ERR:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State, request latch, write-data and writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            type_q       <= '0;
            rd_q         <= '0;
            bram_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= (state_q == S_LD_WAIT);
            if ((state_q == S_IDLE) && req_valid_i) begin
                addr_q <= req_addr_al;
                type_q <= req_type_i;
                rd_q   <= req_rd_i;
                if (req_we_i) bram_wdata_q <= req_wdata_i;
            end
            if (state_q == S_RMW_WAIT) bram_wdata_q <= st_merged;
            if (state_q == S_LD_WAIT) begin
                wb_data_q <= ld_ext;
                wb_rd_q   <= rd_q;
            end
        end
    end

    assign bram_addr_o  = addr_q[ADDR_W-1:2];
    assign bram_wdata_o = bram_wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - Self-checking bench for mem_lsu (table vectors, reset aborts, random vs byte-level model)
module tb_mem_lsu;
    localparam logic [2:0] T_B = 3'd0, T_H = 3'd1, T_W = 3'd2, T_BU = 3'd4, T_HU = 3'd5;
    localparam int K_LOAD = 0, K_WST = 1, K_SST = 2, K_ERR = 3, K_DROP = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
    localparam logic [31:0] ROW13 = 32'hCAFEF00D;
`else
    localparam bit TRAP = 1'b0;
    localparam logic [31:0] ROW13 = 32'hCAFE1234;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [2:0]  req_type_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        bram_en_o, bram_we_o;
    logic [29:0] bram_addr_o;
    logic [31:0] bram_wdata_o;
    logic [31:0] bram_rdata_i = '0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    int n_vec = 0;
    int n_bad = 0;

    mem_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_type_i(req_type_i), .req_rd_i(req_rd_i),
        .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
        .bram_wdata_o(bram_wdata_o), .bram_rdata_i(bram_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    // Word-wide BRAM with one-cycle read latency
    logic [31:0] mem [0:255] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bram_en_o) begin
            if (bram_we_o) mem[bram_addr_o[7:0]] <= bram_wdata_o;
            else           bram_rdata_i <= mem[bram_addr_o[7:0]];
        end
    end

    // Reference memory kept as bytes
    logic [7:0] rmem [0:1023] = '{default: 8'h00};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    // Architectural effect of one request: kind, word index, and load result or written word
    task automatic model(input logic we, input logic [2:0] typ, input logic [9:0] addr,
                         input logic [31:0] wdata, output int kind,
                         output logic [31:0] idx, output logic [31:0] data);
        int sz;
        bit sgn;
        int a;
        sz = 0; sgn = 0; data = '0; idx = '0;
        case (typ)
            T_B:  begin sz = 1; sgn = 1; end
            T_H:  begin sz = 2; sgn = 1; end
            T_W:  sz = 4;
            T_BU: sz = 1;
            T_HU: sz = 2;
            default: sz = 0;
        endcase
        a = int'(addr);
        if (sz != 0 && (a % sz) != 0 && TRAP) begin
            kind = K_ERR;
        end else begin
            if (sz != 0) a = a - (a % sz);
            idx = 32'(a / 4);
            if (!we) begin
                kind = K_LOAD;
                for (int i = 0; i < sz; i++) data |= 32'(rmem[a + i]) << (8 * i);
                if (sgn && sz < 4 && rmem[a + sz - 1][7]) data |= 32'hFFFF_FFFF << (8 * sz);
            end else if (sz == 0) begin
                kind = K_DROP;
            end else begin
                kind = (sz == 4) ? K_WST : K_SST;
                for (int i = 0; i < sz; i++) rmem[a + i] = wdata[8 * i +: 8];
                for (int i = 0; i < 4; i++) data |= 32'(rmem[(a & ~3) + i]) << (8 * i);
            end
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] typ, input logic [9:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        req_valid_i = 1'b1; req_we_i = we; req_type_i = typ;
        req_addr_i = {22'h0, addr}; req_wdata_i = wdata; req_rd_i = rd;
    endtask

    task automatic scramble_req();
        req_valid_i = 1'b0; req_we_i = 1'($urandom); req_addr_i = $urandom;
        req_wdata_i = $urandom; req_type_i = 3'($urandom); req_rd_i = 5'($urandom);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready_o && guard < 16) begin @(negedge clk); guard++; end
        chk("ready_wait", 32'(req_ready_o), 32'd1);
    endtask

    // One request from acceptance until ready returns; timing and data checked against the model
    task automatic run_req(input logic we, input logic [2:0] typ, input logic [9:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input bit use_tab, input logic [31:0] tab_exp);
        int kind, rdy_k;
        logic [31:0] m_idx, m_data;
        logic [7:0] en_m, we_m, wb_m, mis_m;
        logic [31:0] g_raddr, g_waddr, g_wdata, g_wb, g_rd;
        logic [7:0] e_en, e_we, e_wb, e_mis;
        int e_rdy;
        wait_ready();
        model(we, typ, addr, wdata, kind, m_idx, m_data);
        if (use_tab) m_data = tab_exp;
        drive_req(we, typ, addr, wdata, rd);
        @(posedge clk);
        en_m = '0; we_m = '0; wb_m = '0; mis_m = '0; rdy_k = 0;
        g_raddr = 'x; g_waddr = 'x; g_wdata = 'x; g_wb = 'x; g_rd = 'x;
        for (int k = 1; k <= 7 && rdy_k == 0; k++) begin
            @(negedge clk);
            if (k == 1) scramble_req();
            en_m[k] = bram_en_o; we_m[k] = bram_we_o; wb_m[k] = wb_valid_o; mis_m[k] = misalign_o;
            if (bram_en_o && !bram_we_o) g_raddr = 32'(bram_addr_o);
            if (bram_we_o) begin g_waddr = 32'(bram_addr_o); g_wdata = bram_wdata_o; end
            if (wb_valid_o) begin g_wb = wb_data_o; g_rd = 32'(wb_rd_o); end
            if (req_ready_o) rdy_k = k;
        end
        e_en = '0; e_we = '0; e_wb = '0; e_mis = '0;
        case (kind)
            K_LOAD: begin e_rdy = 3; e_en = 8'b0000_0010; e_wb = 8'b0000_1000; end
            K_WST:  begin e_rdy = 2; e_en = 8'b0000_0010; e_we = 8'b0000_0010; end
            K_SST:  begin e_rdy = 4; e_en = 8'b0000_1010; e_we = 8'b0000_1000; end
            K_ERR:  begin e_rdy = 2; e_mis = 8'b0000_0010; end
            default: e_rdy = 1;
        endcase
        chk("ready_cycle", 32'(rdy_k), 32'(e_rdy));
        chk("en_pattern", 32'(en_m), 32'(e_en));
        chk("we_pattern", 32'(we_m), 32'(e_we));
        chk("wb_valid_pattern", 32'(wb_m), 32'(e_wb));
        chk("misalign_pattern", 32'(mis_m), 32'(e_mis));
        if (kind == K_LOAD) begin
            chk("load_addr", g_raddr, m_idx);
            chk("wb_data", g_wb, m_data);
            chk("wb_rd", g_rd, 32'(rd));
        end
        if (kind == K_WST || kind == K_SST) begin
            chk("store_addr", g_waddr, m_idx);
            chk("store_wdata", g_wdata, m_data);
        end
        if (kind == K_SST) chk("rmw_read_addr", g_raddr, m_idx);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_ctl"}, 32'({bram_en_o, bram_we_o, wb_valid_o, misalign_o}), 32'd0);
        chk({tag, "_bram_addr"}, 32'(bram_addr_o), 32'd0);
        chk({tag, "_bram_wdata"}, bram_wdata_o, 32'd0);
        chk({tag, "_wb"}, {wb_data_o ^ 32'(wb_rd_o)}, 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
    endtask

    // Reset during the second busy cycle (RMW_WAIT or LD_WAIT): no write, no writeback
    task automatic abort_req(input logic we, input logic [2:0] typ, input logic [9:0] addr,
                             input logic [31:0] wdata);
        wait_ready();
        drive_req(we, typ, addr, wdata, 5'd7);
        @(posedge clk);
        @(negedge clk);
        scramble_req();
        chk("abort_k1_we", 32'(bram_we_o), 32'd0);
        @(negedge clk);
        chk("abort_k2_we", 32'(bram_we_o), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold", 32'({bram_we_o, wb_valid_o}), 32'd0);
            if (i == 1) rst_n = 1'b1;
        end
        chk_reset_outputs("abort_after");
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;
    vec_t tab [20];

    initial begin
        tab[0]  = '{1'b1, T_W,  10'h100, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
        tab[1]  = '{1'b0, T_W,  10'h100, 32'h0,        5'd1,  32'hDEADBEEF};
        tab[2]  = '{1'b1, T_W,  10'h200, 32'h11223344, 5'd0,  32'h11223344};
        tab[3]  = '{1'b1, T_B,  10'h201, 32'hFFFFFFAB, 5'd0,  32'h1122AB44};
        tab[4]  = '{1'b0, T_W,  10'h200, 32'h0,        5'd2,  32'h1122AB44};
        tab[5]  = '{1'b1, T_W,  10'h300, 32'h80FF7F01, 5'd0,  32'h80FF7F01};
        tab[6]  = '{1'b0, T_B,  10'h303, 32'h0,        5'd3,  32'hFFFFFF80};
        tab[7]  = '{1'b0, T_BU, 10'h303, 32'h0,        5'd4,  32'h00000080};
        tab[8]  = '{1'b0, T_H,  10'h302, 32'h0,        5'd5,  32'hFFFF80FF};
        tab[9]  = '{1'b0, T_HU, 10'h300, 32'h0,        5'd6,  32'h00007F01};
        tab[10] = '{1'b1, T_W,  10'h400, 32'hCAFEF00D, 5'd0,  32'hCAFEF00D};
        tab[11] = '{1'b1, T_H,  10'h401, 32'h00001234, 5'd0,  32'hCAFE1234};
        tab[12] = '{1'b0, T_W,  10'h402, 32'h0,        5'd8,  32'hCAFE1234};
        tab[13] = '{1'b0, T_W,  10'h400, 32'h0,        5'd9,  ROW13};
        tab[14] = '{1'b0, 3'd3, 10'h100, 32'h0,        5'd10, 32'h00000000};
        tab[15] = '{1'b1, 3'd7, 10'h100, 32'hFFFFFFFF, 5'd0,  32'h0};
        tab[16] = '{1'b0, T_W,  10'h100, 32'h0,        5'd11, 32'hDEADBEEF};
        tab[17] = '{1'b1, T_H,  10'h302, 32'h0000BEEF, 5'd0,  32'hBEEF7F01};
        tab[18] = '{1'b0, T_B,  10'h301, 32'h0,        5'd12, 32'h0000007F};
        tab[19] = '{1'b0, T_HU, 10'h302, 32'h0,        5'd13, 32'h0000BEEF};

        repeat (2) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        for (int i = 0; i < 20; i++)
            run_req(tab[i].we, tab[i].typ, tab[i].addr, tab[i].wdata, tab[i].rd, 1'b1, tab[i].exp);

        abort_req(1'b1, T_B, 10'h202, 32'h00000055);
        run_req(1'b0, T_W, 10'h200, 32'h0, 5'd14, 1'b1, 32'h1122AB44);
        abort_req(1'b0, T_W, 10'h300, 32'h0);
        run_req(1'b0, T_W, 10'h100, 32'h0, 5'd15, 1'b1, 32'hDEADBEEF);

        for (int i = 0; i < 120; i++) begin
            logic [2:0] typ;
            case ($urandom_range(0, 9))
                0, 1:    typ = T_B;
                2, 3:    typ = T_H;
                4, 5:    typ = T_W;
                6:       typ = T_BU;
                7:       typ = T_HU;
                8:       typ = 3'd3;
                default: typ = 3'd6;
            endcase
            run_req(1'($urandom_range(0, 1)), typ, 10'($urandom_range(0, 1023)),
                    $urandom, 5'($urandom_range(0, 31)), 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
